// File: rtl/sub16_iter_if.sv
// Operand/result bundle for the nibble-serial subtractor.
// The master drives the request side; the slave (the subtractor) drives status and results.
interface sub16_iter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             B_In;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             b_out;
  logic             ovf;

  modport master (
    output start, A, B, B_In,
    input  busy, done, Diff, b_out, ovf
  );

  modport slave (
    input  start, A, B, B_In,
    output busy, done, Diff, b_out, ovf
  );
endinterface

// File: rtl/sub16_iter.sv
// Nibble-serial subtractor: Diff = A - B - B_In, one NIB-bit slice per cycle, LSB slice first.
// Results are published only on the completion edge and held until the next one or reset.
module sub16_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NIB   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sub16_iter_if.slave bus
);

  // WIDTH must be a multiple of NIB with at least two slices.
  localparam int unsigned STEPS = WIDTH / NIB;
  localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] diff_q;
  logic [KW-1:0]    k;
  logic             borrow;
  logic             done_q;
  logic             b_out_q;
  logic             ovf_q;

  logic [NIB:0]     step;
  logic [WIDTH-1:0] result;
  logic             last;
  logic             accept;
  logic             ovf_next;

  // Operands shift right each cycle so the active slice always sits in the low NIB bits;
  // on the final slice those low bits hold the original sign bits of A and B.
  always_comb begin
    step     = {1'b0, a_sh[NIB-1:0]} - {1'b0, b_sh[NIB-1:0]} - (NIB+1)'(borrow);
    result   = {step[NIB-1:0], acc[WIDTH-1:NIB]};
    last     = (k == K_LAST);
    accept   = bus.start && ((state == IDLE) || (state == DONE));
    ovf_next = (a_sh[NIB-1] != b_sh[NIB-1]) && (step[NIB-1] != a_sh[NIB-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      diff_q  <= '0;
      k       <= '0;
      borrow  <= 1'b0;
      done_q  <= 1'b0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state  <= CALC;
        a_sh   <= bus.A;
        b_sh   <= bus.B;
        borrow <= bus.B_In;
        k      <= '0;
      end else begin
        case (state)
          CALC: begin
            a_sh   <= a_sh >> NIB;
            b_sh   <= b_sh >> NIB;
            acc    <= result;
            borrow <= step[NIB];
            k      <= k + KW'(1);
            if (last) begin
              state   <= DONE;
              diff_q  <= result;
              b_out_q <= step[NIB];
              ovf_q   <= ovf_next;
              done_q  <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.busy  = (state == CALC);
    bus.done  = done_q;
    bus.Diff  = diff_q;
    bus.b_out = b_out_q;
    bus.ovf   = ovf_q;
  end

endmodule

// File: tb/tb_sub16_iter.sv
// Scoreboarded bench for sub16_iter: stimulus pushes expected results, a monitor pops on done.
module tb_sub16_iter;

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sub16_iter_if #(.WIDTH(16)) bus ();

  sub16_iter #(.WIDTH(16), .NIB(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  exp_t        q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the definition: 17-bit unsigned difference.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] r;
    exp_t e;
    r    = {1'b0, a} - {1'b0, b} - 17'(bin);
    e.d  = r[15:0];
    e.bo = r[16];
    e.ov = (a[15] != b[15]) && (r[15] != a[15]);
    return e;
  endfunction

  // Monitor: results must appear only with done, and hold steady otherwise.
  exp_t        held;
  exp_t        got;
  int          busy_run = 0;
  initial begin
    held.d  = '0;
    held.bo = 1'b0;
    held.ov = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held.d   = '0;
      held.bo  = 1'b0;
      held.ov  = 1'b0;
      busy_run = 0;
    end else begin
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", busy_run, 4);
        busy_run = 0;
      end
      if (bus.done) begin
        check("done_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          got = q.pop_front();
          check("diff",  bus.Diff,  got.d);
          check("b_out", bus.b_out, got.bo);
          check("ovf",   bus.ovf,   got.ov);
          held = got;
        end
      end else begin
        check("hold_diff",  bus.Diff,  held.d);
        check("hold_b_out", bus.b_out, held.bo);
        check("hold_ovf",   bus.ovf,   held.ov);
      end
    end
  end

  task automatic wait_done(output int unsigned t);
    logic seen;
    seen = 1'b0;
    t    = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
    end
    check("done_seen", seen, 1);
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int unsigned t;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.B_In  = bin;
    q.push_back(model(a, b, bin));
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    bus.B_In  = 1'($urandom);
    wait_done(t);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  bus.busy,  0);
    check({tag, "_done"},  bus.done,  0);
    check({tag, "_diff"},  bus.Diff,  0);
    check({tag, "_b_out"}, bus.b_out, 0);
    check({tag, "_ovf"},   bus.ovf,   0);
  endtask

  initial begin
    int unsigned t1;
    int unsigned t2;
    int          dones;
    logic [15:0] ra;
    logic [15:0] rb;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.B_In  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    op(16'h0090, 16'h0010, 1'b1);
    check("tp1_diff", bus.Diff, 16'h007F);
    check("tp1_b_out", bus.b_out, 0);
    check("tp1_ovf", bus.ovf, 0);

    op(16'h0000, 16'h0001, 1'b0);
    check("wrap_diff", bus.Diff, 16'hFFFF);
    check("wrap_b_out", bus.b_out, 1);
    op(16'h8000, 16'h0001, 1'b0);
    check("ovf_diff", bus.Diff, 16'h7FFF);
    check("ovf_flag", bus.ovf, 1);
    op(16'h0635, 16'h0635, 1'b1);
    check("eq_bin_diff", bus.Diff, 16'hFFFF);
    check("eq_bin_b_out", bus.b_out, 1);
    op(16'h1234, 16'hFFFF, 1'b1);
    check("full_sub_diff", bus.Diff, 16'h1234);
    check("full_sub_b_out", bus.b_out, 1);

    // Back-to-back with start held high; operands change while the first op is in flight.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'h8046;
    bus.B     = 16'h0005;
    bus.B_In  = 1'b0;
    q.push_back(model(16'h8046, 16'h0005, 1'b0));
    q.push_back(model(16'hC421, 16'h8006, 1'b0));
    @(negedge clk);
    bus.A = 16'hC421;
    bus.B = 16'h8006;
    wait_done(t1);
    check("b2b_first", bus.Diff, 16'h8041);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    wait_done(t2);
    check("b2b_second", bus.Diff, 16'h441B);
    check("b2b_spacing", t2 - t1, 5);

    // Asynchronous reset two cycles after the accepting edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'h5555;
    bus.B     = 16'h1111;
    bus.B_In  = 1'b0;
    q.push_back(model(16'h5555, 16'h1111, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero_outputs("async_rst");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_done_after_abort", dones, 0);
    op(16'h5555, 16'h1111, 1'b0);
    check("post_rst_diff", bus.Diff, 16'h4444);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '1;
        2: rb = ra;
        default: ;
      endcase
      op(ra, rb, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/sub16_iter.md
Name: sub16_iter

Overview:
- 16-bit unsigned/two's-complement subtractor that computes Diff = A - B - B_In.
- Works nibble-serially, LSB nibble first, over 4 compute cycles.
- It is the inverse-operation companion to the 16-bit carry-lookahead adder. The datapath uses a 4-bit borrow chain; a start/busy/done handshake sequences it.
- Used where area matters more than latency, and as a golden-checkable counterpart in adder/subtractor benches.

Parameters:
- WIDTH, 16: operand width; must be a multiple of NIB.
- NIB, 4: bits processed per compute cycle; compute cycles = WIDTH/NIB (default 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an operation; sampled at rising clk.
- A  input  16  minuend; sampled only on the accepting edge.
- B  input  16  subtrahend; sampled only on the accepting edge.
- B_In  input  1  borrow-in; sampled only on the accepting edge.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- Diff  output  16  result A - B - B_In, modulo 2^16.
- b_out  output  1  borrow-out: 1 iff A < B + B_In, treating A, B and B_In as unsigned.
- ovf  output  1  signed overflow: A[15] != B[15] and Diff[15] != A[15].

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. When asserted, state goes to IDLE; busy, done, b_out and ovf are 0, Diff is 16'h0000, and the nibble counter and internal registers clear. Reset aborts any in-flight operation immediately; no done is produced for it.
- States:
  - IDLE: start=1 moves to CALC and latches A, B and B_In into internal registers. The running borrow is initialised to B_In and the nibble index k to 0.
  - CALC: each edge computes {borrow, nibble k of Diff} = A_k - B_k - borrow and increments k. On the edge that processes k = 3, state moves to DONE. On that same edge Diff, b_out and ovf update from the completed internal result and done is set.
  - DONE: lasts one cycle, with done = 1. The next edge clears done. If start = 1 on that edge, new operands are latched and state goes to CALC (back-to-back operation). Otherwise state goes to IDLE.
- Latency: start is accepted at edge E0, nibbles compute at edges E1 to E4, and done is high in the cycle after E4. The earliest next accept is E5, so throughput is one operation per 5 cycles.
- busy = (state == CALC); it is high for exactly 4 cycles per operation.
- start in CALC is ignored; the operands in flight are unaffected.
- Input changes after the accepting edge have no effect.
- Diff, b_out and ovf hold their last values through IDLE and CALC, changing only on a completion edge or reset. Partial nibbles are never visible on Diff.
- Arithmetic is modulo 2^16. Wrap-around: 0x0000 - 0x0001 gives 0xFFFF with b_out = 1.
- B_In = 1 with B = 0xFFFF is legal: A - 0x10000 gives Diff = A with b_out = 1.

Test Plan:
- Reset, then A=0x0090, B=0x0010, B_In=1, start pulse → busy for 4 cycles, done pulse; Diff=0x007F, b_out=0, ovf=0.
- A=0x0000, B=0x0001, B_In=0 → Diff=0xFFFF, b_out=1, ovf=0. Then A=0x8000, B=0x0001, B_In=0 → Diff=0x7FFF, b_out=0, ovf=1.
- A=0x0635, B=0x0635, B_In=1 → Diff=0xFFFF, b_out=1. Then A=0x1234, B=0xFFFF, B_In=1 → Diff=0x1234, b_out=1.
- Back-to-back ops:
  - Hold start high continuously with A=0x8046, B=0x0005 then A=0xC421, B=0x8006.
  - Done pulses 5 cycles apart; results are 0x8041 then 0x441B.
  - Start while busy is ignored, and changing A mid-CALC does not alter the result.
- Reset mid-operation: assert rst_n=0 asynchronously (mid-cycle) two cycles after the accepting edge. All outputs go to 0 immediately, and no done follows after release. A fresh operation after reset completes correctly.
- Random self-check: ≥1000 random A/B/B_In values against the reference expression {b_out, Diff} = {1'b0, A} - {1'b0, B} - B_In, plus the ovf formula.
